// File: rtl/bcd_display_driver.sv
// Three-digit 7-segment driver for the keypad calculator result.
// Iterative double-dabble (one bit per clock), then per-digit encode.
module bcd_display_driver #(
    parameter int WIDTH          = 10,
    parameter int BLANK_LEADING  = 1,
    parameter int SEG_ACTIVE_LOW = 0
) (
    input  logic             clk_in,
    input  logic             rst_n,
    input  logic             load,
    input  logic [WIDTH-1:0] value,
    output logic             busy,
    output logic             done,
    output logic             overflow,
    output logic [20:0]      display
);

    typedef enum logic [1:0] {
        IDLE,
        SHIFT,
        UPDATE
    } state_t;

    localparam logic [3:0]  LAST = 4'(WIDTH - 1);
    localparam logic [20:0] OFF  =
        (SEG_ACTIVE_LOW != 0) ? {21{1'b1}} : 21'd0;
    localparam logic [6:0]  DASH = 7'h40;

    state_t           state_q;
    state_t           state_d;
    logic [WIDTH-1:0] shift_q;
    logic [15:0]      bcd_q;
    logic [15:0]      bcd_adj;
    logic [3:0]       count_q;
    logic [20:0]      disp_d;
    logic             ovf_d;
    logic [6:0]       seg_h;
    logic [6:0]       seg_t;
    logic [6:0]       seg_u;

    function automatic logic [6:0] seg7(input logic [3:0] d);
        logic [6:0] s;
        unique case (d)
            4'd0:    s = 7'h3F;
            4'd1:    s = 7'h06;
            4'd2:    s = 7'h5B;
            4'd3:    s = 7'h4F;
            4'd4:    s = 7'h66;
            4'd5:    s = 7'h6D;
            4'd6:    s = 7'h7D;
            4'd7:    s = 7'h07;
            4'd8:    s = 7'h7F;
            4'd9:    s = 7'h6F;
            default: s = 7'h00;
        endcase
        return s;
    endfunction

    assign busy = (state_q != IDLE);

    always_ff @(posedge clk_in) begin
        if (!rst_n) begin
            state_q  <= IDLE;
            shift_q  <= '0;
            bcd_q    <= '0;
            count_q  <= '0;
            done     <= 1'b0;
            overflow <= 1'b0;
            display  <= OFF;
        end else begin
            state_q <= state_d;
            done    <= 1'b0;
            unique case (state_q)
                IDLE: begin
                    if (load) begin
                        shift_q <= value;
                        bcd_q   <= '0;
                        count_q <= '0;
                    end
                end
                SHIFT: begin
                    {bcd_q, shift_q} <= {bcd_adj, shift_q} << 1;
                    count_q          <= count_q + 4'd1;
                end
                UPDATE: begin
                    display  <= disp_d;
                    overflow <= ovf_d;
                    done     <= 1'b1;
                end
                default: ;
            endcase
        end
    end

    always_comb begin
        state_d = state_q;
        unique case (state_q)
            IDLE:    if (load) state_d = SHIFT;
            SHIFT:   if (count_q == LAST) state_d = UPDATE;
            UPDATE:  state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    // Add-3 correction happens before the shift within the same edge.
    always_comb begin
        bcd_adj = bcd_q;
        for (int i = 0; i < 4; i++) begin
            if (bcd_q[4*i +: 4] >= 4'd5)
                bcd_adj[4*i +: 4] = bcd_q[4*i +: 4] + 4'd3;
        end
    end

    always_comb begin
        ovf_d = (bcd_q[15:12] != 4'd0);
        seg_h = seg7(bcd_q[11:8]);
        seg_t = seg7(bcd_q[7:4]);
        seg_u = seg7(bcd_q[3:0]);
        if (BLANK_LEADING != 0 && bcd_q[11:8] == 4'd0) begin
            seg_h = 7'h00;
            if (bcd_q[7:4] == 4'd0)
                seg_t = 7'h00;
        end
        if (ovf_d)
            disp_d = {DASH, DASH, DASH};
        else
            disp_d = {seg_h, seg_t, seg_u};
        // XOR with the reset pattern applies common-anode inversion.
        disp_d = disp_d ^ OFF;
    end

endmodule

// File: doc/bcd_display_driver.md
Name: bcd_display_driver

Overview:
- Output side of the keypad calculator: accepts a binary result on a load strobe and drives three 7-segment digits on a 21-bit display bus.
- Converts binary to BCD with an iterative double-dabble state machine, one bit per clock, then encodes each digit to segments.
- Registers the display, raises busy/done handshake flags, and flags values that do not fit in three digits.

Parameters:
- WIDTH, 10, bit width of the binary input; legal range 4..10; also the number of shift iterations.
- BLANK_LEADING, 1, if 1, leading zero digits are blanked; the units digit is never blanked.
- SEG_ACTIVE_LOW, 0, if 1, every segment output is inverted (common-anode panel).

Ports:
- clk_in  input  1  system clock; all logic is on its rising edge.
- rst_n  input  1  synchronous active-low reset.
- load  input  1  one-cycle strobe; sampled only in IDLE.
- value  input  WIDTH  unsigned binary number to display, captured when load is accepted.
- busy  output  1  high from the load-accept edge until the display-update edge.
- done  output  1  one-cycle pulse in the cycle after the display updates.
- overflow  output  1  registered with display; 1 when the captured value is greater than 999.
- display  output  21  [20:14] hundreds, [13:7] tens, [6:0] units; within each digit bit0=a through bit6=g.

Behaviour:
- Clock and reset: one clock, clk_in. Reset is synchronous and active-low on rst_n.
- Reset (rst_n=0 at a clock edge):
  - State goes to IDLE; busy=0, done=0, overflow=0.
  - All display segments are off: 0 per segment, or 1 when SEG_ACTIVE_LOW=1.
  - Shift register, BCD register and iteration counter clear.
  - Reset takes effect at any point, including mid-conversion; the in-flight conversion is discarded and the display is blanked.
- States: IDLE, SHIFT, UPDATE.
- IDLE:
  - done=0.
  - On an edge with load=1: capture value into the shift register, clear the 16-bit BCD register (4 digits), set count=0, set busy=1, go to SHIFT.
- SHIFT:
  - Each edge: every BCD digit >=5 is first incremented by 3, then {bcd, shift} shifts left by 1.
  - count increments each edge. After WIDTH edges (count = WIDTH-1 on the last one), go to UPDATE.
- UPDATE, one edge:
  - Register display and overflow; busy=0; done=1; return to IDLE.
  - done drops on the next edge.
- Latency: load accepted at edge E0; display, overflow and done change at edge E0+WIDTH+1 (E0+11 at default WIDTH).
- load handling:
  - load while busy=1 is ignored; there is no queueing.
  - load during the cycle done=1 is accepted, because the state is IDLE.
  - value is sampled only on the accept edge; later changes to value have no effect.
- Overflow:
  - The thousands BCD digit is nonzero or the value is >999: overflow=1 and all three digits show a dash (g only, 0x40).
  - This case is reachable only when WIDTH=10.
- Segment codes, active-high before polarity is applied:
  - 0=0x3F, 1=0x06, 2=0x5B, 3=0x4F, 4=0x66, 5=0x6D, 6=0x7D, 7=0x07, 8=0x7F, 9=0x6F.
  - Blank=0x00. Dash=0x40.
- Blanking when BLANK_LEADING=1:
  - The hundreds digit is blank if it is 0.
  - The tens digit is blank if both hundreds and tens are 0.
  - The units digit is always shown, so value 0 displays "  0".
- Polarity: the SEG_ACTIVE_LOW inversion applies to all 21 bits, including blank and dash codes.
- display holds its value between conversions; it changes only in UPDATE or on reset.

Test Plan:
- Reset, then load value=123 → busy high for 11 cycles; done pulses once at E0+11; display = {0x06,0x5B,0x4F}; overflow=0.
- Load 7, then 0, with BLANK_LEADING=1 → {0x00,0x00,0x07}, then {0x00,0x00,0x3F}. Repeat with BLANK_LEADING=0 → {0x3F,0x3F,0x07}.
- Load 999 → {0x6F,0x6F,0x6F}, overflow=0. Load 1000 and 1023 → {0x40,0x40,0x40}, overflow=1.
- Load 45, then load=1 again with value=88 on cycles E0+3 and E0+11 (while busy) → display ends at 45 only; load=1 with value=88 in the done cycle → second conversion runs and display becomes {0x00,0x7F,0x7F}.
- Load 500, assert rst_n=0 at E0+5 → next cycle busy=0, done=0, display all-off; done never pulses for the aborted conversion.
- SEG_ACTIVE_LOW=1, load 210 → {~0x5B,~0x06,~0x3F} masked to 7 bits; after reset, display = 21'h1FFFFF.
